axi_aw_decoder_tracked: RTL and testbench

- Next-generation AXI4 AW-channel address decoder for one slave port of the interconnect.
- Decodes AW addresses against a parametrised per-initiator-port region map and routes each address to exactly one initiator port (one-hot); lowest index wins on overlapping regions.
- Owns an internal outstanding-write counter and a same-destination ordering lock.
- Unmapped addresses go to a programmable default port, or get a self-contained DECERR handling path: W-beat sink sized by AWLEN, then a B response carrying the captured AWID.

---
 rtl/axi_aw_decoder_tracked.sv | 207 ++++++++++++++++++++
 tb/tb_axi_aw_decoder_tracked.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_aw_decoder_tracked.sv
// AXI4 AW-channel decoder: region-map routing with an outstanding-write counter,
// a same-destination ordering lock and a local DECERR path (W sink plus B response).
// Region flat vectors are region-major: entry index = r*N_INIT_PORT + p.
module axi_aw_decoder_tracked #(
  parameter int ADDR_WIDTH      = 32,
  parameter int ID_WIDTH        = 4,
  parameter int N_INIT_PORT     = 8,
  parameter int N_REGION        = 2,
  parameter int MAX_OUTSTANDING = 8,
  parameter int DEFAULT_PORT    = 0,
  localparam int CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      awvalid_i,
  output logic                                      awready_o,
  input  logic [ADDR_WIDTH-1:0]                     awaddr_i,
  input  logic [ID_WIDTH-1:0]                       awid_i,
  input  logic [7:0]                                awlen_i,
  output logic [N_INIT_PORT-1:0]                    awvalid_o,
  input  logic [N_INIT_PORT-1:0]                    awready_i,
  input  logic                                      grant_FIFO_DEST_i,
  output logic [N_INIT_PORT-1:0]                    DEST_o,
  output logic                                      push_DEST_o,
  input  logic [N_REGION*N_INIT_PORT*ADDR_WIDTH-1:0] START_ADDR_i,
  input  logic [N_REGION*N_INIT_PORT*ADDR_WIDTH-1:0] END_ADDR_i,
  input  logic [N_REGION*N_INIT_PORT-1:0]           enable_region_i,
  input  logic [N_INIT_PORT-1:0]                    connectivity_map_i,
  input  logic                                      default_en_i,
  input  logic                                      bdone_i,
  output logic [CNT_W-1:0]                          outstanding_o,
  input  logic                                      err_wvalid_i,
  output logic                                      err_wready_o,
  output logic                                      err_bvalid_o,
  input  logic                                      err_bready_i,
  output logic [ID_WIDTH-1:0]                       err_bid_o,
  output logic [1:0]                                err_bresp_o,
  output logic                                      handle_error_o
);

  localparam int PORT_W = (N_INIT_PORT > 1) ? $clog2(N_INIT_PORT) : 1;

  typedef enum logic [1:0] {
    OPERATIVE = 2'd0,
    DRAIN     = 2'd1,
    ERR_WDATA = 2'd2,
    ERR_BRESP = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [PORT_W-1:0]   lock_q, lock_d;
  logic [ID_WIDTH-1:0] id_q, id_d;
  logic [7:0]          len_q, len_d;
  logic [7:0]          beat_q, beat_d;

  logic [N_INIT_PORT-1:0] hit_s;
  logic [N_INIT_PORT-1:0] dest_s;
  logic [PORT_W-1:0]      sel_s;
  logic                   err_s;
  logic                   full_s;
  logic                   stall_s;
  logic                   route_ok_s;
  logic                   err_accept_s;
  logic                   aw_hs_s;
  logic                   dec_s;

  // Address decode: region hits, lowest-index priority, default-port fallback.
  always_comb begin
    hit_s  = '0;
    sel_s  = '0;
    err_s  = 1'b0;
    dest_s = '0;
    for (int p = 0; p < N_INIT_PORT; p++) begin
      for (int r = 0; r < N_REGION; r++) begin
        hit_s[p] = hit_s[p] |
                   (enable_region_i[r*N_INIT_PORT + p] &
                    (awaddr_i >= START_ADDR_i[(r*N_INIT_PORT + p)*ADDR_WIDTH +: ADDR_WIDTH]) &
                    (awaddr_i <= END_ADDR_i[(r*N_INIT_PORT + p)*ADDR_WIDTH +: ADDR_WIDTH]));
      end
    end
    hit_s = hit_s & connectivity_map_i;
    for (int p = N_INIT_PORT - 1; p >= 0; p--) begin
      if (hit_s[p]) begin
        sel_s = PORT_W'(p);
      end else begin
        sel_s = sel_s;
      end
    end
    if (hit_s == '0) begin
      if (default_en_i) begin
        sel_s = PORT_W'(DEFAULT_PORT);
      end else begin
        err_s = 1'b1;
      end
    end else begin
      err_s = 1'b0;
    end
    for (int p = 0; p < N_INIT_PORT; p++) begin
      dest_s[p] = ~err_s & (sel_s == PORT_W'(p));
    end
  end

  // AW pass-through, stall conditions and all externally visible outputs.
  always_comb begin
    full_s       = (count_q == CNT_W'(MAX_OUTSTANDING));
    stall_s      = ~grant_FIFO_DEST_i | full_s | ((count_q != '0) & (sel_s != lock_q));
    route_ok_s   = rst_n & (state_q == OPERATIVE) & ~err_s & ~stall_s;
    err_accept_s = rst_n & (state_q == OPERATIVE) & err_s & awvalid_i &
                   grant_FIFO_DEST_i & ~full_s;
    aw_hs_s      = route_ok_s & awvalid_i & awready_i[sel_s];
    dec_s        = bdone_i & (count_q != '0);

    awvalid_o      = route_ok_s ? (dest_s & {N_INIT_PORT{awvalid_i}}) : '0;
    awready_o      = (route_ok_s & awready_i[sel_s]) | err_accept_s;
    push_DEST_o    = aw_hs_s;
    DEST_o         = rst_n ? dest_s : '0;
    outstanding_o  = rst_n ? count_q : '0;
    handle_error_o = rst_n & (state_q == ERR_WDATA);
    err_wready_o   = rst_n & (state_q == ERR_WDATA);
    err_bvalid_o   = rst_n & (state_q == ERR_BRESP);
    err_bid_o      = err_bvalid_o ? id_q : '0;
    err_bresp_o    = 2'b11;
  end

  // Next-state for counter, ordering lock and the error-path FSM.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    len_d   = len_q;
    beat_d  = beat_q;
    if (aw_hs_s && !dec_s) begin
      count_d = count_q + CNT_W'(1);
    end else if (!aw_hs_s && dec_s) begin
      count_d = count_q - CNT_W'(1);
    end else begin
      count_d = count_q;
    end
    if (aw_hs_s) begin
      lock_d = sel_s;
    end else begin
      lock_d = lock_q;
    end
    case (state_q)
      OPERATIVE: begin
        if (err_accept_s) begin
          id_d    = awid_i;
          len_d   = awlen_i;
          state_d = DRAIN;
        end else begin
          state_d = OPERATIVE;
        end
      end
      DRAIN: begin
        if (count_q == '0) begin
          state_d = ERR_WDATA;
        end else begin
          state_d = DRAIN;
        end
      end
      ERR_WDATA: begin
        if (err_wvalid_i) begin
          beat_d = beat_q + 8'd1;
          if (beat_q == len_q) begin
            state_d = ERR_BRESP;
          end else begin
            state_d = ERR_WDATA;
          end
        end else begin
          state_d = ERR_WDATA;
        end
      end
      ERR_BRESP: begin
        if (err_bready_i) begin
          beat_d  = 8'd0;
          state_d = OPERATIVE;
        end else begin
          state_d = ERR_BRESP;
        end
      end
      default: begin
        beat_d  = 8'd0;
        state_d = OPERATIVE;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= OPERATIVE;
      count_q <= '0;
      lock_q  <= '0;
      id_q    <= '0;
      len_q   <= 8'd0;
      beat_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      lock_q  <= lock_d;
      id_q    <= id_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
    end
  end

endmodule

// File: tb/tb_axi_aw_decoder_tracked.sv
// Directed bench: decode vector table plus hand-written routing, stall, error-path and reset sequences.
module tb_axi_aw_decoder_tracked;

  localparam int AW   = 32;
  localparam int IDW  = 4;
  localparam int NP   = 8;
  localparam int NR   = 2;
  localparam int MAXO = 2;
  localparam int CW   = $clog2(MAXO + 1);

  logic              clk;
  logic              rst_n;
  logic              awvalid_i;
  logic              awready_o;
  logic [AW-1:0]     awaddr_i;
  logic [IDW-1:0]    awid_i;
  logic [7:0]        awlen_i;
  logic [NP-1:0]     awvalid_o;
  logic [NP-1:0]     awready_i;
  logic              grant_i;
  logic [NP-1:0]     dest_o;
  logic              push_o;
  logic [NR*NP*AW-1:0] start_addr;
  logic [NR*NP*AW-1:0] end_addr;
  logic [NR*NP-1:0]  enable_region;
  logic [NP-1:0]     conn_map;
  logic              default_en;
  logic              bdone_i;
  logic [CW-1:0]     outstanding_o;
  logic              err_wvalid_i;
  logic              err_wready_o;
  logic              err_bvalid_o;
  logic              err_bready_i;
  logic [IDW-1:0]    err_bid_o;
  logic [1:0]        err_bresp_o;
  logic              handle_error_o;

  int n_tests = 0;
  int n_fail  = 0;

  axi_aw_decoder_tracked #(
    .ADDR_WIDTH(AW), .ID_WIDTH(IDW), .N_INIT_PORT(NP), .N_REGION(NR),
    .MAX_OUTSTANDING(MAXO), .DEFAULT_PORT(7)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .awvalid_i(awvalid_i), .awready_o(awready_o), .awaddr_i(awaddr_i),
    .awid_i(awid_i), .awlen_i(awlen_i),
    .awvalid_o(awvalid_o), .awready_i(awready_i),
    .grant_FIFO_DEST_i(grant_i), .DEST_o(dest_o), .push_DEST_o(push_o),
    .START_ADDR_i(start_addr), .END_ADDR_i(end_addr),
    .enable_region_i(enable_region), .connectivity_map_i(conn_map),
    .default_en_i(default_en), .bdone_i(bdone_i), .outstanding_o(outstanding_o),
    .err_wvalid_i(err_wvalid_i), .err_wready_o(err_wready_o),
    .err_bvalid_o(err_bvalid_o), .err_bready_i(err_bready_i),
    .err_bid_o(err_bid_o), .err_bresp_o(err_bresp_o),
    .handle_error_o(handle_error_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        def_en;
    logic [7:0]  exp_dest;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_region(input int r, input int p, input logic [31:0] s, input logic [31:0] e);
    start_addr[(r*NP + p)*AW +: AW] = s;
    end_addr[(r*NP + p)*AW +: AW]   = e;
    enable_region[r*NP + p]         = 1'b1;
  endtask

  initial begin
    vecs[0]  = '{32'h0000_1900, 1'b0, 8'h04};
    vecs[1]  = '{32'h0000_1000, 1'b0, 8'h04};
    vecs[2]  = '{32'h0000_1FFF, 1'b0, 8'h04};
    vecs[3]  = '{32'h0000_2000, 1'b0, 8'h08};
    vecs[4]  = '{32'h0000_2FFF, 1'b0, 8'h08};
    vecs[5]  = '{32'h0000_3000, 1'b0, 8'h00};
    vecs[6]  = '{32'h0000_3000, 1'b1, 8'h80};
    vecs[7]  = '{32'h0000_4000, 1'b0, 8'h02};
    vecs[8]  = '{32'h0000_6ABC, 1'b0, 8'h20};
    vecs[9]  = '{32'h0000_7000, 1'b0, 8'h00};
    vecs[10] = '{32'h0000_7000, 1'b1, 8'h80};
    vecs[11] = '{32'h0000_0FFF, 1'b0, 8'h00};

    start_addr    = '0;
    end_addr      = '0;
    enable_region = '0;
    set_region(0, 2, 32'h0000_1000, 32'h0000_1FFF);
    set_region(0, 3, 32'h0000_1800, 32'h0000_2FFF);
    set_region(0, 1, 32'h0000_4000, 32'h0000_4FFF);
    set_region(0, 4, 32'h0000_5000, 32'h0000_5FFF);
    set_region(1, 5, 32'h0000_6000, 32'h0000_6FFF);
    set_region(0, 6, 32'h0000_7000, 32'h0000_7FFF);
    conn_map = 8'hBF;

    rst_n = 1'b0; awvalid_i = 1'b0; awaddr_i = 32'h0000_1900; awid_i = 4'd0;
    awlen_i = 8'd0; awready_i = 8'hFF; grant_i = 1'b1; default_en = 1'b0;
    bdone_i = 1'b0; err_wvalid_i = 1'b0; err_bready_i = 1'b0;

    #2;
    chk("rst_dest", {24'd0, dest_o}, 32'h0);
    chk("rst_bresp", {30'd0, err_bresp_o}, 32'h3);
    tick(); tick();
    chk("rst_outst", {30'd0, outstanding_o}, 32'h0);
    chk("rst_herr", {31'd0, handle_error_o}, 32'h0);
    rst_n = 1'b1;
    #2;
    chk("post_rst_awvalid", {24'd0, awvalid_o}, 32'h0);
    tick();

    for (int i = 0; i < 12; i++) begin
      awaddr_i   = vecs[i].addr;
      default_en = vecs[i].def_en;
      #2;
      chk($sformatf("decode[%0d]", i), {24'd0, dest_o}, {24'd0, vecs[i].exp_dest});
      tick();
    end
    default_en = 1'b0;

    // Basic routed write, overlapping regions -> port 2
    awaddr_i = 32'h0000_1900; awvalid_i = 1'b1;
    #2;
    chk("route_awvalid", {24'd0, awvalid_o}, 32'h04);
    chk("route_awready", {31'd0, awready_o}, 32'h1);
    chk("route_push", {31'd0, push_o}, 32'h1);
    tick();
    awvalid_i = 1'b0;
    #2;
    chk("route_outst", {30'd0, outstanding_o}, 32'h1);
    chk("route_push_off", {31'd0, push_o}, 32'h0);
    bdone_i = 1'b1;
    tick();
    bdone_i = 1'b0;
    #2;
    chk("bdone_outst", {30'd0, outstanding_o}, 32'h0);

    // Fill to MAX_OUTSTANDING on port 1
    awaddr_i = 32'h0000_4000; awvalid_i = 1'b1;
    tick(); tick();
    #2;
    chk("full_outst", {30'd0, outstanding_o}, 32'h2);
    chk("full_awready", {31'd0, awready_o}, 32'h0);
    chk("full_awvalid", {24'd0, awvalid_o}, 32'h0);
    bdone_i = 1'b1;
    #1;
    chk("full_bdone_awready", {31'd0, awready_o}, 32'h0);
    tick();
    #2;
    chk("inc_dec_awready", {31'd0, awready_o}, 32'h1);
    chk("inc_dec_push", {31'd0, push_o}, 32'h1);
    tick();
    bdone_i = 1'b0; awvalid_i = 1'b0;
    #2;
    chk("inc_dec_outst", {30'd0, outstanding_o}, 32'h1);

    // Ordering lock: count=1 on port 1, AW to port 4 stalls until drained
    awaddr_i = 32'h0000_5000; awvalid_i = 1'b1;
    #2;
    chk("lock_stall_awvalid", {24'd0, awvalid_o}, 32'h0);
    chk("lock_stall_awready", {31'd0, awready_o}, 32'h0);
    tick();
    bdone_i = 1'b1;
    #2;
    chk("lock_stall_bdone", {31'd0, awready_o}, 32'h0);
    tick();
    bdone_i = 1'b0;
    #2;
    chk("lock_release_awvalid", {24'd0, awvalid_o}, 32'h10);
    chk("lock_release_awready", {31'd0, awready_o}, 32'h1);
    tick();
    #2;
    chk("lock4_outst", {30'd0, outstanding_o}, 32'h1);
    chk("lock4_same_port", {24'd0, awvalid_o}, 32'h10);
    awvalid_i = 1'b0;

    // FIFO grant low blocks routing
    tick();
    grant_i = 1'b0; awaddr_i = 32'h0000_5000; awvalid_i = 1'b1;
    #2;
    chk("nogrant_awvalid", {24'd0, awvalid_o}, 32'h0);
    chk("nogrant_awready", {31'd0, awready_o}, 32'h0);
    grant_i = 1'b1; awvalid_i = 1'b0;
    tick();

    // Error write with 1 outstanding (lock 4)
    awaddr_i = 32'hF000_0000; awid_i = 4'd5; awlen_i = 8'd3; awvalid_i = 1'b1;
    #2;
    chk("err_awready", {31'd0, awready_o}, 32'h1);
    chk("err_awvalid", {24'd0, awvalid_o}, 32'h0);
    chk("err_push", {31'd0, push_o}, 32'h0);
    chk("err_dest", {24'd0, dest_o}, 32'h0);
    tick();
    #2;
    chk("drain_awready", {31'd0, awready_o}, 32'h0);
    awvalid_i = 1'b0;
    tick();
    chk("drain_hold", {31'd0, handle_error_o}, 32'h0);
    bdone_i = 1'b1;
    tick();
    bdone_i = 1'b0;
    #2;
    chk("drain_outst", {30'd0, outstanding_o}, 32'h0);
    chk("drain_still", {31'd0, handle_error_o}, 32'h0);
    tick();
    #2;
    chk("wdata_herr", {31'd0, handle_error_o}, 32'h1);
    chk("wdata_wready", {31'd0, err_wready_o}, 32'h1);
    err_wvalid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("beat%0d_herr", i), {31'd0, handle_error_o}, 32'h1);
      tick();
    end
    err_wvalid_i = 1'b0;
    #2;
    chk("bresp_valid", {31'd0, err_bvalid_o}, 32'h1);
    chk("bresp_id", {28'd0, err_bid_o}, 32'h5);
    chk("bresp_resp", {30'd0, err_bresp_o}, 32'h3);
    chk("bresp_herr", {31'd0, handle_error_o}, 32'h0);
    tick();
    chk("bresp_hold", {31'd0, err_bvalid_o}, 32'h1);
    err_bready_i = 1'b1;
    tick();
    err_bready_i = 1'b0;
    #2;
    chk("bresp_done", {31'd0, err_bvalid_o}, 32'h0);
    awaddr_i = 32'h0000_1900; awvalid_i = 1'b1;
    #1;
    chk("back_oper_awready", {31'd0, awready_o}, 32'h1);
    awvalid_i = 1'b0;
    tick();

    // Unmapped address with default enabled -> port 7
    awaddr_i = 32'hF000_0000; default_en = 1'b1; awvalid_i = 1'b1;
    #2;
    chk("dflt_awvalid", {24'd0, awvalid_o}, 32'h80);
    chk("dflt_push", {31'd0, push_o}, 32'h1);
    tick();
    awvalid_i = 1'b0;
    #2;
    chk("dflt_outst", {30'd0, outstanding_o}, 32'h1);
    chk("dflt_no_err", {31'd0, handle_error_o}, 32'h0);
    bdone_i = 1'b1;
    tick();
    bdone_i = 1'b0; default_en = 1'b0;

    // Reset taken during ERR_WDATA
    awaddr_i = 32'hF000_0000; awid_i = 4'd9; awlen_i = 8'd7; awvalid_i = 1'b1;
    tick();
    awvalid_i = 1'b0;
    tick();
    #2;
    chk("rst2_in_wdata", {31'd0, handle_error_o}, 32'h1);
    err_wvalid_i = 1'b1;
    tick();
    rst_n = 1'b0;
    #2;
    chk("rst2_during", {31'd0, handle_error_o}, 32'h0);
    tick();
    rst_n = 1'b1; err_wvalid_i = 1'b0;
    #2;
    chk("rst2_herr", {31'd0, handle_error_o}, 32'h0);
    chk("rst2_wready", {31'd0, err_wready_o}, 32'h0);
    chk("rst2_bvalid", {31'd0, err_bvalid_o}, 32'h0);
    chk("rst2_outst", {30'd0, outstanding_o}, 32'h0);
    chk("rst2_bresp", {30'd0, err_bresp_o}, 32'h3);
    awaddr_i = 32'h0000_1900; awvalid_i = 1'b1;
    #1;
    chk("rst2_oper", {31'd0, awready_o}, 32'h1);
    awvalid_i = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
